// File: rtl/pc_control_fsm.sv
// Moore control FSM feeding the program counter, IR load and datapath controls.
// Optional single-step mode under CTRL_SINGLE_STEP_EN adds a step input and WAIT_STEP state.
module pc_control_fsm #(
  parameter logic [2:0] ALU_PASS = 3'd0,
  parameter logic [2:0] ALU_ADD  = 3'd1,
  parameter logic [2:0] ALU_SUB  = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_NOOP = 4'd3,
    S_LOAD_A = 4'd4, S_LOAD_B = 4'd5, S_STORE = 4'd6, S_ADD = 4'd7,
    S_SUB = 4'd8, S_HALT = 4'd9, S_WAIT_STEP = 4'd10
  } state_t;

  state_t cur;
  state_t done_nxt;

  // Where an instruction goes once its execute phase is finished.
`ifdef CTRL_SINGLE_STEP_EN
  assign done_nxt = S_WAIT_STEP;
`else
  assign done_nxt = S_FETCH;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_INIT;
    end else begin
      case (cur)
        S_INIT:   cur <= S_FETCH;
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (IR[15:12])
            4'h1:    cur <= S_STORE;
            4'h2:    cur <= S_LOAD_A;
            4'h3:    cur <= S_ADD;
            4'h4:    cur <= S_SUB;
            4'h5:    cur <= S_HALT;
            default: cur <= S_NOOP;
          endcase
        end
        S_LOAD_A: cur <= S_LOAD_B;
        S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: cur <= done_nxt;
        S_HALT:   cur <= S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
        S_WAIT_STEP: if (step) cur <= S_FETCH;
`endif
        default:  cur <= S_INIT;
      endcase
    end
  end

  // Outputs decode straight from state so reset pulls the strobes low without a clock.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = ALU_PASS;
    case (cur)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        PC_up = 1'b1;
        IR_ld = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = IR[11:4];
        RF_s      = 1'b1;
        RF_W_addr = IR[3:0];
        RF_W_en   = (cur == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (cur == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_pc_control_fsm.sv
// Directed-vector bench for pc_control_fsm; covers single-step mode when CTRL_SINGLE_STEP_EN is set.
module tb_pc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
  logic [2:0]  ALU_s0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_control_fsm dut (
    .clk(clk),
    .reset(reset),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .IR(IR),
    .PC_clr(PC_clr),
    .PC_up(PC_up),
    .IR_ld(IR_ld),
    .D_addr(D_addr),
    .D_wr(D_wr),
    .RF_s(RF_s),
    .RF_W_addr(RF_W_addr),
    .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0),
    .state(state)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves an execute state and lands in FETCH (via WAIT_STEP when stepping).
  task automatic to_fetch(input string tag);
    tick();
`ifdef CTRL_SINGLE_STEP_EN
    chk({tag, "_wait"}, 16'(state), 16'd10);
    tick();
`endif
    chk({tag, "_fetch"}, 16'(state), 16'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strobes"}, {10'd0, PC_clr, PC_up, IR_ld, D_wr, RF_W_en, RF_s}, 16'd0);
    chk({tag, "_addr"}, {D_addr, RF_W_addr, RF_Ra_addr}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    step  = 1'b1;
    IR    = 16'h0000;
    repeat (3) tick();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_clr", 16'(PC_clr), 16'd1);
    chk("rst_rest", {12'd0, PC_up, IR_ld, D_wr, RF_W_en}, 16'd0);

    reset = 1'b0;
    tick();
    chk("fetch_state", 16'(state), 16'd1);
    chk("fetch_strobes", {13'd0, PC_clr, PC_up, IR_ld}, 16'b011);

    // LOAD
    IR = 16'h2A35;
    tick();
    chk("ld_decode", 16'(state), 16'd2);
    chk_idle("ld_decode");
    tick();
    chk("ld_a_state", 16'(state), 16'd4);
    chk("ld_a_addr", 16'(D_addr), 16'h00A3);
    chk("ld_a_rf", {8'd0, RF_W_addr, 2'd0, RF_s, RF_W_en}, 16'h0052);
    tick();
    chk("ld_b_state", 16'(state), 16'd5);
    chk("ld_b_rf", {8'd0, RF_W_addr, 2'd0, RF_s, RF_W_en}, 16'h0053);
    chk("ld_b_addr", 16'(D_addr), 16'h00A3);
    to_fetch("ld");

    // STORE
    IR = 16'h1C47;
    tick();
    tick();
    chk("st_state", 16'(state), 16'd6);
    chk("st_out", {D_addr, RF_Ra_addr, 2'd0, D_wr, RF_W_en}, 16'h47C2);
    to_fetch("st");
    chk("st_wr_off", 16'(D_wr), 16'd0);

    // ADD then SUB
    IR = 16'h3128;
    tick();
    tick();
    chk("add_state", 16'(state), 16'd7);
    chk("add_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr, 4'd0}, 16'h1280);
    chk("add_ctl", {11'd0, RF_W_en, RF_s, ALU_s0}, 16'h0011);
    to_fetch("add");
    IR = 16'h4128;
    tick();
    tick();
    chk("sub_state", 16'(state), 16'd8);
    chk("sub_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr, 4'd0}, 16'h1280);
    chk("sub_ctl", {11'd0, RF_W_en, RF_s, ALU_s0}, 16'h0012);
    to_fetch("sub");

    // Undefined opcode behaves as NOOP
    IR = 16'hF000;
    tick();
    tick();
    chk("noop_state", 16'(state), 16'd3);
    chk_idle("noop");
    chk("noop_alu", 16'(ALU_s0), 16'd0);
    to_fetch("noop");

    // Reset in the middle of STORE
    IR = 16'h1C47;
    tick();
    tick();
    chk("mid_st_wr", 16'(D_wr), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", 16'(state), 16'd0);
    chk("mid_rst_wr", 16'(D_wr), 16'd0);
    chk("mid_rst_clr", 16'(PC_clr), 16'd1);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_fetch", 16'(state), 16'd1);

`ifdef CTRL_SINGLE_STEP_EN
    IR = 16'h3128;
    step = 1'b0;
    tick();
    tick();
    chk("ss_add", 16'(state), 16'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ss_hold", 16'(state), 16'd10);
      chk("ss_hold_out", {14'd0, PC_up, RF_W_en}, 16'd0);
    end
    step = 1'b1;
    tick();
    chk("ss_release", 16'(state), 16'd1);
`endif

    // HALT is absorbing
    IR = 16'h5000;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", 16'(state), 16'd9);
      chk("halt_up", 16'(PC_up), 16'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_control_fsm.md
Name: pc_control_fsm

Overview:
Moore-style control state machine directly upstream of the program counter. It drives the counter's synchronous clear and count-up strobes and the instruction-register load strobe, then decodes the fetched 16-bit instruction. It issues the data-memory, register-file and ALU control signals for the datapath. One instruction completes per pass through FETCH → DECODE → execute state(s).

Parameters:
ALU_PASS, 3'd0, ALU select driven in every state other than ADD/SUB
ALU_ADD, 3'd1, ALU select driven in ADD
ALU_SUB, 3'd2, ALU select driven in SUB

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; forces INIT immediately
IR  input  16  instruction register contents; [15:12] opcode
PC_clr  output  1  synchronous clear strobe to program counter
PC_up  output  1  count-up strobe to program counter
IR_ld  output  1  instruction register load enable
D_addr  output  8  data memory address
D_wr  output  1  data memory write enable
RF_s  output  1  register-file write mux: 1 = data memory, 0 = ALU
RF_W_addr  output  4  register-file write address
RF_W_en  output  1  register-file write enable
RF_Ra_addr  output  4  register-file read port A address
RF_Rb_addr  output  4  register-file read port B address
ALU_s0  output  3  ALU function select
state  output  4  current state encoding, for display/debug

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, WAIT_STEP=10 (optional feature only).
- Opcodes (IR[15:12]): 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. Opcodes 0110–1111 decode as NOOP.
- Transitions:
  - INIT→FETCH.
  - FETCH→DECODE.
  - DECODE→{NOOP, STORE, LOAD_A, ADD, SUB, HALT} per opcode.
  - LOAD_A→LOAD_B.
  - NOOP/LOAD_B/STORE/ADD/SUB→FETCH.
  - HALT→HALT until reset.
- Outputs are pure functions of state and IR; no output registers.
- Default for all outputs is 0; only the values listed below are driven per state.
- INIT: PC_clr=1.
- FETCH: PC_up=1, IR_ld=1. IR captures the word at the current PC while the counter increments on the same edge.
- DECODE, NOOP, HALT: all defaults.
- LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. This state covers the synchronous memory read latency.
- LOAD_B: same as LOAD_A plus RF_W_en=1.
- STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1.
- ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=ALU_ADD.
- SUB: same as ADD with ALU_s0=ALU_SUB.
- Latency in cycles, FETCH to next FETCH: NOOP 3, STORE 3, ADD 3, SUB 3, LOAD 4.
- Reset:
  - Assertion in any state moves to INIT without waiting for a clock.
  - While reset is held: state=0, PC_clr=1, all other outputs 0.
  - D_wr and RF_W_en drop combinationally on reset assertion, including mid-STORE and mid-LOAD_B.
- After reset release, the first rising edge moves INIT→FETCH. The counter therefore sees PC_clr on at least one edge before the first PC_up.
- PC_clr and PC_up are never asserted together. D_wr and RF_W_en are never asserted together.
- PC wrap from 127 to 0 is handled in the counter; this block is unaware of it.

Optional Feature:
Macro CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit, synchronous to clk).
  - NOOP, LOAD_B, STORE, ADD and SUB go to WAIT_STEP instead of FETCH.
  - WAIT_STEP holds all outputs at defaults and moves to FETCH on the first edge with step=1.
  - INIT still goes directly to FETCH.
  - Reset from WAIT_STEP behaves as from any other state.
- Undefined: no step port, WAIT_STEP is unreachable, and the transitions are as listed in Behaviour.

Test Plan:
- Reset held 3 cycles then released → state=0 and PC_clr=1 during reset; next edge state=1 with PC_up=1 and IR_ld=1.
- IR=16'h2A35 (LOAD) → DECODE→LOAD_A with D_addr=8'hA3, RF_W_addr=4'h5, RF_s=1, RF_W_en=0; then LOAD_B with RF_W_en=1; then FETCH. 4 cycles total.
- IR=16'h1C47 (STORE) → STORE with D_addr=8'h47, RF_Ra_addr=4'hC, D_wr=1 for exactly one cycle.
- IR=16'h3128 then 16'h4128 (ADD/SUB) → Ra=1, Rb=2, W=8, RF_W_en=1, ALU_s0=1 then 2.
- IR=16'h5000 (HALT) → state=9 for 20 cycles with PC_up never asserted; IR=16'hF000 → NOOP path. Reset asserted mid-STORE → D_wr=0 and state=0 before the next edge.
- With CTRL_SINGLE_STEP_EN, ADD then step=0 for 5 cycles → state=10 held; step=1 → FETCH on the next edge.
